// File: rtl/diff_out_buf_cfg_pkg.sv
// Shared types and AXI response codes for the differential-output-buffer
// configuration sequencer.
package diff_out_buf_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4,
        NEXT  = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic resp_is_ok(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/diff_out_buf_cfg_sequencer.sv
// AXI4-Lite master that writes a bank of NUM_REGS configuration words and,
// optionally, reads each one back to confirm it landed.
module diff_out_buf_cfg_sequencer
    import diff_out_buf_cfg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter bit          VERIFY     = 1'b1
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [3:0]                     err_index,
    output logic                           err_mismatch,
    output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DATA_WIDTH-1:0]          m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    state_t                         state_q, state_d;
    logic [3:0]                     idx_q, idx_d, nidx_s;
    logic [NUM_REGS*DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic                           awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                           arvalid_q, arvalid_d, bready_q, bready_d;
    logic                           rready_q, rready_d, aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d, busy_q, busy_d;
    logic                           done_q, done_d, error_q, error_d;
    logic [3:0]                     err_index_q, err_index_d;
    logic                           err_mismatch_q, err_mismatch_d;
    logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic                           aw_hs_s, w_hs_s;

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [3:0] idx);
        return ADDR_WIDTH'(BASE_ADDR + {26'd0, idx, 2'b00});
    endfunction

    assign aw_hs_s = awvalid_q && m_axi_awready;
    assign w_hs_s  = wvalid_q && m_axi_wready;
    assign nidx_s  = idx_q + 4'd1;

    // Next-state and next-output computation for the whole sequence
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cfg_d          = cfg_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        arvalid_d      = arvalid_q;
        bready_d       = bready_q;
        rready_d       = rready_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = error_q;
        err_index_d    = err_index_q;
        err_mismatch_d = err_mismatch_q;
        awaddr_d       = awaddr_q;
        araddr_d       = araddr_q;
        wdata_d        = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d          = cfg_data;
                    error_d        = 1'b0;
                    err_index_d    = 4'd0;
                    err_mismatch_d = 1'b0;
                    idx_d          = 4'd0;
                    busy_d         = 1'b1;
                    awvalid_d      = 1'b1;
                    wvalid_d       = 1'b1;
                    aw_done_d      = 1'b0;
                    w_done_d       = 1'b0;
                    awaddr_d       = reg_addr(4'd0);
                    wdata_d        = cfg_data[DATA_WIDTH-1:0];
                    state_d        = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                // AW and W may complete in either order; each valid drops after its own handshake
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end else begin
                    state_d = WR;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (!resp_is_ok(m_axi_bresp)) begin
                        error_d        = 1'b1;
                        err_index_d    = idx_q;
                        err_mismatch_d = 1'b0;
                        busy_d         = 1'b0;
                        state_d        = IDLE;
                    end else if (VERIFY) begin
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(idx_q);
                        state_d   = RD;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    state_d = WRESP;
                end
            end
            RD: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end else begin
                    state_d = RD;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (!resp_is_ok(m_axi_rresp)) begin
                        error_d        = 1'b1;
                        err_index_d    = idx_q;
                        err_mismatch_d = 1'b0;
                        busy_d         = 1'b0;
                        state_d        = IDLE;
                    end else if (m_axi_rdata != cfg_q[DATA_WIDTH*idx_q +: DATA_WIDTH]) begin
                        error_d        = 1'b1;
                        err_index_d    = idx_q;
                        err_mismatch_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            NEXT: begin
                if (idx_q == 4'(NUM_REGS - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    idx_d     = nidx_s;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = reg_addr(nidx_s);
                    wdata_d   = cfg_q[DATA_WIDTH*nidx_s +: DATA_WIDTH];
                    state_d   = WR;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q        <= IDLE;
            idx_q          <= 4'd0;
            cfg_q          <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            bready_q       <= 1'b0;
            rready_q       <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_index_q    <= 4'd0;
            err_mismatch_q <= 1'b0;
            awaddr_q       <= '0;
            araddr_q       <= '0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cfg_q          <= cfg_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            arvalid_q      <= arvalid_d;
            bready_q       <= bready_d;
            rready_q       <= rready_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_index_q    <= err_index_d;
            err_mismatch_q <= err_mismatch_d;
            awaddr_q       <= awaddr_d;
            araddr_q       <= araddr_d;
            wdata_q        <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_index_q;
    assign err_mismatch  = err_mismatch_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_diff_out_buf_cfg_sequencer.sv
// Scoreboard bench: a behavioural AXI4-Lite slave with tunable backpressure and
// fault injection; expected writes and completion events are queued by stimulus.
module tb_diff_out_buf_cfg_sequencer;

    typedef struct { logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit is_err; logic [3:0] idx; bit mism; int lat; } end_t;

    logic         aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, error, err_mismatch;
    logic [3:0]   err_index, awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    wr_t  exp_wr[$];
    end_t exp_end[$];
    int   pass_cnt = 0, chk_cnt = 0, cyc = 0, start_cyc = 0;
    logic chk_reset = 1'b0, chk_drain = 1'b0;

    // slave configuration
    bit         rand_en = 1'b0, err_wr_en = 1'b0, corrupt_en = 1'b0;
    int         aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [3:0] err_wr_addr = 4'h0, corrupt_addr = 4'h0;

    // slave state
    logic        aw_have, w_have, b_pend, r_pend;
    logic [3:0]  aw_addr_s, r_addr_s;
    logic [31:0] w_data_s;
    logic [31:0] mem [0:3];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_lim, w_lim, ar_lim, b_lim, r_lim;
    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [3:0]  wr_addr_obs;
    logic [31:0] wr_data_obs;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    diff_out_buf_cfg_sequencer #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h0), .VERIFY(1'b1)
    ) dut (
        .ACLK(aclk), .ARESETN(aresetn), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .err_mismatch(err_mismatch),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    assign awready     = awvalid && (aw_cnt >= (rand_en ? aw_lim : aw_wait));
    assign wready      = wvalid && (w_cnt >= (rand_en ? w_lim : w_wait));
    assign arready     = arvalid && (ar_cnt >= (rand_en ? ar_lim : ar_wait));
    assign bvalid      = b_pend && (b_cnt >= (rand_en ? b_lim : b_wait));
    assign rvalid      = r_pend && (r_cnt >= (rand_en ? r_lim : r_wait));
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign wr_fire     = (aw_have || aw_hs) && (w_have || w_hs) && !b_pend;
    assign wr_addr_obs = aw_have ? aw_addr_s : awaddr;
    assign wr_data_obs = w_have ? w_data_s : wdata;
    assign rresp       = 2'b00;
    assign rdata       = (corrupt_en && r_addr_s == corrupt_addr) ? 32'h0000_DEAD : mem[r_addr_s[3:2]];

    // behavioural slave: one outstanding write and one outstanding read
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_addr_s <= 4'h0; r_addr_s <= 4'h0; w_data_s <= 32'h0; bresp <= 2'b00;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_lim <= 0; w_lim <= 0; ar_lim <= 0; b_lim <= 0; r_lim <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                aw_have <= 1'b1; aw_addr_s <= awaddr; aw_lim <= int'($urandom_range(0, 7));
            end
            if (w_hs) begin
                w_have <= 1'b1; w_data_s <= wdata; w_lim <= int'($urandom_range(0, 7));
            end
            if (wr_fire) begin
                aw_have <= 1'b0; w_have <= 1'b0;
                mem[wr_addr_obs[3:2]] <= wr_data_obs;
                b_pend <= 1'b1; b_cnt <= 0; b_lim <= int'($urandom_range(0, 7));
                bresp <= (err_wr_en && wr_addr_obs == err_wr_addr) ? 2'b10 : 2'b00;
            end else if (b_pend) begin
                if (bvalid && bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
            if (ar_hs) begin
                r_pend <= 1'b1; r_addr_s <= araddr; r_cnt <= 0;
                r_lim <= int'($urandom_range(0, 7)); ar_lim <= int'($urandom_range(0, 7));
            end else if (r_pend) begin
                if (rvalid && rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
        chk_cnt++;
        if (ok === 1'b1) pass_cnt++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    endtask

    // monitor: compares DUT activity against the queued expectations
    initial begin : monitor
        wr_t  w;
        end_t e;
        logic err_prev;
        logic [63:0] outs;
        err_prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (chk_reset) begin
                outs = {1'b0, awprot, arprot, wstrb, awvalid, wvalid, arvalid, bready, rready,
                        busy, done, error, err_mismatch, err_index, awaddr, araddr, wdata};
                chk("reset_outs", outs == {1'b0, 6'd0, 4'hF, 53'd0}, outs, {1'b0, 6'd0, 4'hF, 53'd0});
            end
            if (wr_fire) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 1'b0, {28'd0, wr_addr_obs, wr_data_obs}, 64'd0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr_data", {wr_addr_obs, wr_data_obs} === {w.addr, w.data},
                        {28'd0, wr_addr_obs, wr_data_obs}, {28'd0, w.addr, w.data});
                end
            end
            if (done) begin
                if (exp_end.size() == 0) begin
                    chk("done_unexpected", 1'b0, 64'd1, 64'd0);
                end else begin
                    e = exp_end.pop_front();
                    chk("done_event", !e.is_err && (e.lat < 0 || cyc - start_cyc == e.lat) && !busy && !error,
                        64'(cyc - start_cyc), 64'(e.lat));
                end
            end
            if (error && !err_prev) begin
                if (exp_end.size() == 0) begin
                    chk("error_unexpected", 1'b0, {59'd0, err_index, err_mismatch}, 64'd0);
                end else begin
                    e = exp_end.pop_front();
                    chk("error_event", e.is_err && err_index == e.idx && err_mismatch == e.mism && !busy,
                        {59'd0, err_index, err_mismatch}, {59'd0, e.idx, e.mism});
                end
            end
            err_prev = error;
            if (chk_drain)
                chk("drain", exp_wr.size() == 0 && exp_end.size() == 0,
                    64'(exp_wr.size() + exp_end.size()), 64'd0);
        end
    end

    task automatic push_writes(input logic [127:0] cfg, input int n);
        for (int i = 0; i < n; i++) exp_wr.push_back('{addr: 4'(4 * i), data: cfg[32*i +: 32]});
    endtask

    task automatic push_end(input bit is_err, input logic [3:0] idx, input bit mism, input int lat);
        exp_end.push_back('{is_err: is_err, idx: idx, mism: mism, lat: lat});
    endtask

    // called just after a posedge; start is high for exactly one cycle
    task automatic pulse_start(input logic [127:0] cfg, input bit record);
        cfg_data = cfg;
        start = 1'b1;
        if (record) start_cyc = cyc;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic flag_pulse(input bit drain);
        if (drain) chk_drain = 1'b1; else chk_reset = 1'b1;
        @(negedge aclk); @(posedge aclk); #1;
        chk_drain = 1'b0; chk_reset = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && exp_end.size() != 0; i++) @(posedge aclk);
        repeat (8) @(posedge aclk);
        #1;
        flag_pulse(1'b1);
    endtask

    localparam logic [127:0] CFG1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] CFG2 = {32'hA5A5_0003, 32'h5A5A_0002, 32'h1234_0001, 32'hCAFE_0000};
    localparam logic [127:0] CFGX = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC};

    initial begin : stimulus
        repeat (2) @(posedge aclk);
        #1;
        flag_pulse(1'b0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // T1: zero-wait slave, done 21 cycles after start; start during FIN is ignored
        push_writes(CFG1, 4); push_end(1'b0, 4'd0, 1'b0, 21);
        pulse_start(CFG1, 1'b1);
        repeat (20) @(posedge aclk);
        #1;
        pulse_start(CFGX, 1'b0);
        wait_end(200);

        // T2: random backpressure on every channel, plus a start while busy
        rand_en = 1'b1;
        push_writes(CFG2, 4); push_end(1'b0, 4'd0, 1'b0, -1);
        pulse_start(CFG2, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        pulse_start(CFGX, 1'b0);
        wait_end(2000);
        rand_en = 1'b0;

        // T3: W accepted before AW, then AW before W
        aw_wait = 1; w_wait = 0;
        push_writes(CFG2 ^ {4{32'h0F0F_0F0F}}, 4); push_end(1'b0, 4'd0, 1'b0, -1);
        pulse_start(CFG2 ^ {4{32'h0F0F_0F0F}}, 1'b1);
        wait_end(400);
        aw_wait = 0; w_wait = 2;
        push_writes(CFG1 << 4, 4); push_end(1'b0, 4'd0, 1'b0, -1);
        pulse_start(CFG1 << 4, 1'b1);
        wait_end(400);
        w_wait = 0;

        // T4: SLVERR on write to 0x8 stops before 0xC
        err_wr_en = 1'b1; err_wr_addr = 4'h8;
        push_writes(CFG1, 3); push_end(1'b1, 4'd2, 1'b0, -1);
        pulse_start(CFG1, 1'b1);
        wait_end(400);
        err_wr_en = 1'b0;

        // T5: corrupted readback of 0x4
        corrupt_en = 1'b1; corrupt_addr = 4'h4;
        push_writes(CFG2, 2); push_end(1'b1, 4'd1, 1'b1, -1);
        pulse_start(CFG2, 1'b1);
        wait_end(400);
        corrupt_en = 1'b0;

        // T6: reset during the write response of register 1, then a full rerun
        push_writes(CFG1, 2);
        pulse_start(CFG1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (bready && awaddr == 4'h4) break;
            @(posedge aclk); #1;
        end
        aresetn = 1'b0;
        flag_pulse(1'b0);
        aresetn = 1'b1;
        flag_pulse(1'b1);
        @(posedge aclk); #1;
        push_writes(CFG1, 4); push_end(1'b0, 4'd0, 1'b0, 21);
        pulse_start(CFG1, 1'b1);
        wait_end(200);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
